// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module   : branch_history_table
//  Purpose  : Direct-mapped branch target buffer with a 2-bit history counter
//             per entry. The fetch-side lookup and the upd_pc history read are
//             combinational. The mem-stage update is written on the clock
//             edge. Saturating counters track resolved and mispredicted
//             branches.
//  Revision : 1.0  initial release
// ============================================================================
module branch_history_table #(
  parameter int ENTRIES = 16,
  parameter int IDXW    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] fetch_pc,
  output logic        hit,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  output logic [1:0]  upd_history,
  input  logic [1:0]  upd_history_new,
  input  logic        wrong_prediction,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int          TAGW       = 32 - IDXW - 2;
  localparam logic [1:0]  C_CTR_INIT = 2'b01;
  localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

  // Table storage, one slot per index
  logic              valid_q  [ENTRIES];
  logic [TAGW-1:0]   tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [15:0]       branch_count_q, branch_count_d;
  logic [15:0]       mispredict_count_q, mispredict_count_d;

  logic [IDXW-1:0]   w_fetch_idx;
  logic [TAGW-1:0]   w_fetch_tag;
  logic [IDXW-1:0]   w_upd_idx;
  logic [TAGW-1:0]   w_upd_tag;
  logic              w_upd_hit;

  // Byte-offset bits of the update PC carry no information for word-aligned PCs
  logic              unused_pc_bits;
  assign unused_pc_bits = ^upd_pc[1:0];

  assign w_fetch_idx = fetch_pc[IDXW+1:2];
  assign w_fetch_tag = fetch_pc[31:IDXW+2];
  assign w_upd_idx   = upd_pc[IDXW+1:2];
  assign w_upd_tag   = upd_pc[31:IDXW+2];

  // Fetch-side lookup. This path has no bypass from a write in the same
  // cycle, so a colliding update becomes visible one cycle later.
  always_comb begin
    hit            = valid_q[w_fetch_idx] && (tag_q[w_fetch_idx] == w_fetch_tag);
    predict_taken  = hit && ctr_q[w_fetch_idx][1];
    predict_target = predict_taken ? target_q[w_fetch_idx] : (fetch_pc + 32'd4);
  end

  // History read for the resolving branch; a miss reports weak not-taken
  always_comb begin
    w_upd_hit   = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);
    upd_history = w_upd_hit ? ctr_q[w_upd_idx] : C_CTR_INIT;
  end

  // Next value of the saturating statistics counters
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd_en) begin
      if (branch_count_q != C_CNT_MAX) begin
        branch_count_d = branch_count_q + 16'd1;
      end
      if (wrong_prediction && (mispredict_count_q != C_CNT_MAX)) begin
        mispredict_count_d = mispredict_count_q + 16'd1;
      end
    end
  end

  // Table write: an update overwrites the indexed slot whatever it held
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= C_CTR_INIT;
      end
    end else if (upd_en) begin
      valid_q[w_upd_idx]  <= 1'b1;
      tag_q[w_upd_idx]    <= w_upd_tag;
      target_q[w_upd_idx] <= upd_target;
      ctr_q[w_upd_idx]    <= upd_history_new;
    end
  end

  // Statistics counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 SHALL have parameters:
- ENTRIES, default 16, number of direct-mapped entries (power of two).
- IDXW, default 4, index width, equal to log2(ENTRIES).
REQ-002 SHALL run on one clock; reset is asynchronous and active-high.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  – rising-edge clock.
- RST  in  1  – asynchronous active-high reset.
- fetch_pc  in  32  – fetch-stage lookup PC, word aligned.
- hit  out  1  – lookup entry valid and tag match.
- predict_taken  out  1  – fetch prediction.
- predict_target  out  32  – next-PC suggestion.
- upd_en  in  1  – mem-stage branch resolving this cycle (branch_mem).
- upd_pc  in  32  – PC of the resolving branch.
- upd_target  in  32  – resolved taken-target of the branch.
- upd_history  out  2  – stored counter for upd_pc; fed to the predictor as branch_history.
- upd_history_new  in  2  – next counter returned by the predictor.
- wrong_prediction  in  1  – resolving branch was mispredicted.
- branch_count  out  16  – resolved branches, saturating.
- mispredict_count  out  16  – mispredictions, saturating.

Function
REQ-004 SHALL decode the address fields as follows:
- index = pc[IDXW+1:2].
- tag = pc[31:IDXW+2].
- pc[1:0] ignored.
REQ-005 SHALL give each entry these fields:
- valid (1 bit).
- tag (32-IDXW-2 bits).
- target (32 bits).
- counter (2 bits; 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-006 SHALL drive the lookup outputs combinationally from fetch_pc in the same cycle:
- hit = valid & tag match.
- predict_taken = hit & counter[1].
- predict_target = target when predict_taken, else fetch_pc+4, with the sum wrapping modulo 2^32.
REQ-007 SHALL drive upd_history combinationally:
- On an upd_pc hit, the stored counter.
- On a miss, 2'b01.
REQ-008 SHALL write the update on the rising CLK edge when upd_en=1:
- valid=1.
- tag from upd_pc.
- target=upd_target.
- counter=upd_history_new.
REQ-009 SHALL replace any existing entry at the update index on a tag mismatch, with no replacement policy beyond overwrite.
REQ-010 SHALL make no table change when upd_en=0; upd_history_new, upd_target and wrong_prediction are then ignored.
REQ-011 SHALL have no bypass: when fetch_pc and upd_pc map to the same index in the same cycle, the lookup returns pre-update contents, and the write is visible from the next cycle.
REQ-012 SHALL increment branch_count by 1 on each clock edge with upd_en=1, holding at 16'hFFFF.
REQ-013 SHALL increment mispredict_count by 1 on each clock edge with upd_en=1 and wrong_prediction=1, holding at 16'hFFFF.
REQ-014 SHALL update both counters and the table entry in the same edge when all apply.
REQ-015 SHALL write upd_history_new unchanged, with no saturation check; the predictor owns counter arithmetic.
REQ-016 SHALL give every stored value single-cycle write latency, and the outputs SHALL have zero-cycle combinational read latency.

Reset
REQ-017 SHALL, while RST=1 and independent of CLK:
- clear all valid bits.
- set all counters to 2'b01.
- set all targets and tags to 0.
- set branch_count and mispredict_count to 0.
REQ-018 SHALL, during reset, produce hit=0, predict_taken=0, predict_target=fetch_pc+4 and upd_history=2'b01.
REQ-019 SHALL give reset priority over a simultaneous upd_en: a reset asserted mid-operation discards the pending update.
REQ-020 SHALL take the first update on the first rising edge after RST deasserts.

Verification
REQ-021 SHALL pass cold lookup: after reset, fetch_pc=0x0000_0040 -> hit=0, predict_taken=0, predict_target=0x0000_0044, upd_history=01.
REQ-022 SHALL pass allocate-then-hit:
- Cycle n: upd_en=1, upd_pc=0x40, upd_target=0x100, upd_history_new=10.
- Cycle n+1: fetch_pc=0x40 -> hit=1, predict_taken=1, predict_target=0x100.
- Cycle n+1: upd_pc=0x40 -> upd_history=10.
REQ-023 SHALL pass alias replacement: allocate 0x40 (counter 11), then update 0x440 (same index 0, different tag, counter 00) -> fetch_pc=0x40 gives hit=0; fetch_pc=0x440 gives hit=1, predict_taken=0, predict_target=0x444.
REQ-024 SHALL pass same-index collision: update 0x80 with counter 11 while fetch_pc=0x80 in the same cycle -> that cycle hit=0; next cycle hit=1, predict_taken=1.
REQ-025 SHALL pass counter saturation: 65540 cycles of upd_en=1, wrong_prediction=1 -> branch_count=mispredict_count=16'hFFFF, no wrap.
REQ-026 SHALL pass mid-operation reset: populate 4 entries, assert RST asynchronously between edges together with upd_en=1 -> outputs immediately show hit=0 and counts=0; after deassert, all four PCs miss.
